touch_point_qualifier: RTL

//  Sits between the capacitive-touch sample reader and the touch region decoder. It debounces

---
 rtl/touch_point_qualifier.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/touch_point_qualifier.sv
// touch_point_qualifier
//   Debounces touch press/release from the capacitive sample reader, clamps each
//   coordinate to the active area and box-averages it over 2**AVG_LOG2 samples.
//   While not pressed the output word is parked at {IDLE_X, IDLE_Y}.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high reset
//   tp_valid      1-cycle strobe: new sample on tp_touch/tp_x/tp_y
//   tp_touch      sample carries a touch point (only meaningful with tp_valid)
//   tp_x, tp_y    raw 16-bit coordinates
//   data_out      {x_avg[15:0], y_avg[15:0]} to the region decoder
//   pressed       high in HELD and REL_QUAL
//   press_pulse   1-cycle pulse on entry to HELD from IDLE/PRESS_QUAL
//   release_pulse 1-cycle pulse on qualified release or timeout from HELD/REL_QUAL
module touch_point_qualifier #(
    parameter int unsigned H_ACT       = 1024,
    parameter int unsigned V_ACT       = 600,
    parameter int unsigned PRESS_N     = 3,
    parameter int unsigned RELEASE_N   = 2,
    parameter int unsigned AVG_LOG2    = 2,
    parameter int unsigned TIMEOUT_CYC = 500000,
    parameter int unsigned IDLE_X      = 0,
    parameter int unsigned IDLE_Y      = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tp_valid,
    input  logic        tp_touch,
    input  logic [15:0] tp_x,
    input  logic [15:0] tp_y,
    output logic [31:0] data_out,
    output logic        pressed,
    output logic        press_pulse,
    output logic        release_pulse
);

    localparam int unsigned WIN    = 1 << AVG_LOG2;
    localparam int unsigned ACC_W  = 16 + AVG_LOG2;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [15:0]      X_MAX     = 16'(H_ACT - 1);
    localparam logic [15:0]      Y_MAX     = 16'(V_ACT - 1);
    localparam logic [3:0]       PRESS_W   = 4'(PRESS_N);
    localparam logic [3:0]       RELEASE_W = 4'(RELEASE_N);
    localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [31:0]      IDLE_WORD = {16'(IDLE_X), 16'(IDLE_Y)};

    typedef enum logic [1:0] {
        IDLE,
        PRESS_QUAL,
        HELD,
        REL_QUAL
    } state_t;

    state_t           state, state_n;
    logic [3:0]       qual_cnt, qual_cnt_n;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_n;
    logic [15:0]      win_x [WIN];
    logic [15:0]      win_y [WIN];
    logic [15:0]      win_x_n [WIN];
    logic [15:0]      win_y_n [WIN];
    logic [15:0]      cx, cy;
    logic             touched, untouched, timeout_hit;
    logic             shift_in, flush;
    logic [ACC_W-1:0] sum_x, sum_y;
    logic [15:0]      x_avg, y_avg;
    logic             pressed_n;

    assign cx = (tp_x > X_MAX) ? X_MAX : tp_x;
    assign cy = (tp_y > Y_MAX) ? Y_MAX : tp_y;

    assign touched     = tp_valid &  tp_touch;
    assign untouched   = tp_valid & ~tp_touch;
    // A sample arriving on the would-be timeout cycle wins over the timeout.
    assign timeout_hit = ~tp_valid & (tmo_cnt == TMO_LAST);

    always_comb begin
        tmo_cnt_n = tmo_cnt;
        if (tp_valid) begin
            tmo_cnt_n = '0;
        end else if (tmo_cnt != TMO_MAX) begin
            tmo_cnt_n = tmo_cnt + 1'b1;
        end
    end

    always_comb begin
        state_n    = state;
        qual_cnt_n = qual_cnt;
        shift_in   = 1'b0;
        flush      = 1'b0;
        unique case (state)
            IDLE: begin
                if (touched) begin
                    flush = 1'b1;
                    if (PRESS_N == 1) begin
                        state_n    = HELD;
                        qual_cnt_n = '0;
                    end else begin
                        state_n    = PRESS_QUAL;
                        qual_cnt_n = 4'd1;
                    end
                end
            end
            PRESS_QUAL: begin
                if (touched) begin
                    shift_in = 1'b1;
                    if (qual_cnt + 4'd1 == PRESS_W) begin
                        state_n    = HELD;
                        qual_cnt_n = '0;
                    end else begin
                        qual_cnt_n = qual_cnt + 4'd1;
                    end
                end else if (untouched || timeout_hit) begin
                    state_n    = IDLE;
                    qual_cnt_n = '0;
                end
            end
            HELD: begin
                if (touched) begin
                    shift_in = 1'b1;
                end else if (untouched) begin
                    if (RELEASE_N == 1) begin
                        state_n    = IDLE;
                        qual_cnt_n = '0;
                    end else begin
                        state_n    = REL_QUAL;
                        qual_cnt_n = 4'd1;
                    end
                end else if (timeout_hit) begin
                    state_n    = IDLE;
                    qual_cnt_n = '0;
                end
            end
            REL_QUAL: begin
                if (touched) begin
                    shift_in   = 1'b1;
                    state_n    = HELD;
                    qual_cnt_n = '0;
                end else if (untouched) begin
                    if (qual_cnt + 4'd1 == RELEASE_W) begin
                        state_n    = IDLE;
                        qual_cnt_n = '0;
                    end else begin
                        qual_cnt_n = qual_cnt + 4'd1;
                    end
                end else if (timeout_hit) begin
                    state_n    = IDLE;
                    qual_cnt_n = '0;
                end
            end
            default: begin
                state_n    = IDLE;
                qual_cnt_n = '0;
            end
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < WIN; i++) begin
            win_x_n[i] = win_x[i];
            win_y_n[i] = win_y[i];
        end
        if (flush) begin
            for (int unsigned i = 0; i < WIN; i++) begin
                win_x_n[i] = cx;
                win_y_n[i] = cy;
            end
        end else if (shift_in) begin
            win_x_n[0] = cx;
            win_y_n[0] = cy;
            for (int unsigned i = 1; i < WIN; i++) begin
                win_x_n[i] = win_x[i-1];
                win_y_n[i] = win_y[i-1];
            end
        end
    end

    // Average the next-cycle window so the registered output reflects the
    // qualifying sample exactly one clock later.
    always_comb begin
        sum_x = '0;
        sum_y = '0;
        for (int unsigned i = 0; i < WIN; i++) begin
            sum_x = sum_x + ACC_W'(win_x_n[i]);
            sum_y = sum_y + ACC_W'(win_y_n[i]);
        end
        x_avg = 16'(sum_x >> AVG_LOG2);
        y_avg = 16'(sum_y >> AVG_LOG2);
    end

    assign pressed_n = (state_n == HELD) || (state_n == REL_QUAL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            qual_cnt      <= '0;
            tmo_cnt       <= '0;
            for (int unsigned i = 0; i < WIN; i++) begin
                win_x[i] <= '0;
                win_y[i] <= '0;
            end
            data_out      <= IDLE_WORD;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_n;
            qual_cnt      <= qual_cnt_n;
            tmo_cnt       <= tmo_cnt_n;
            for (int unsigned i = 0; i < WIN; i++) begin
                win_x[i] <= win_x_n[i];
                win_y[i] <= win_y_n[i];
            end
            data_out      <= pressed_n ? {x_avg, y_avg} : IDLE_WORD;
            pressed       <= pressed_n;
            press_pulse   <= (state_n == HELD) &&
                             ((state == IDLE) || (state == PRESS_QUAL));
            release_pulse <= (state_n == IDLE) &&
                             ((state == HELD) || (state == REL_QUAL));
        end
    end

endmodule
